// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes queue in a FIFO and go out LSB first.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_uart,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (CLKS_PER_BIT > 1) ?
                      $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          uart_q, uart_d;
  logic          busy_q, busy_d;
  logic          push, pop, t_last;

  // Writes are refused whenever full, even if a pop happens this cycle.
  assign o_ready = (count_q != FULL);
  assign push    = i_valid & o_ready;
  assign t_last  = (timer_q == T_LAST);

  // Frame sequencing; o_uart is precomputed for the next cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    uart_d  = uart_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        uart_d  = 1'b1;
        timer_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
          uart_d  = 1'b0;
        end
      end
      START: begin
        timer_d = timer_q + TW'(1);
        if (t_last) begin
          timer_d = '0;
          bit_d   = '0;
          state_d = DATA;
          uart_d  = shift_q[0];
        end
      end
      DATA: begin
        timer_d = timer_q + TW'(1);
        if (t_last) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            uart_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            uart_d  = shift_q[1];
          end
        end
      end
      STOP: begin
        timer_d = timer_q + TW'(1);
        if (t_last) begin
          timer_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
            uart_d  = 1'b0;
          end else begin
            state_d = IDLE;
            uart_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        uart_d  = 1'b1;
      end
    endcase
  end

  // Queue bookkeeping and busy flag for the next cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    busy_d   = (state_d != IDLE) | (count_d != '0);
  end

  // Byte storage; contents need no reset as pointers do.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      uart_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      uart_q   <= uart_d;
      busy_q   <= busy_d;
    end
  end

  assign o_uart  = uart_q;
  assign o_busy  = busy_q;
  assign o_count = count_q;

endmodule
